// File: rtl/axi4_txn_scheduler.sv
// Round-robin write/read command issue toward an AXI4 master. It tracks outstanding
// bursts per direction against a credit limit and flags address timeouts and stray responses.
module axi4_txn_scheduler #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_WID   = 4,
  parameter int TMO_CYC   = 255
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               wr_req,
  input  logic               rd_req,
  input  logic               aw_hs,
  input  logic               ar_hs,
  input  logic               wr_done,
  input  logic               rd_done,
  output logic               wr_trn_en,
  output logic               rd_trn_en,
  output logic [CNT_WID-1:0] wr_outst,
  output logic [CNT_WID-1:0] rd_outst,
  output logic               busy,
  output logic               tmo_err,
  output logic               unexp_err
);

  localparam logic [CNT_WID-1:0] MAX_C    = CNT_WID'(MAX_OUTST);
  localparam logic [CNT_WID-1:0] ONE      = CNT_WID'(1);
  localparam logic [7:0]         TMO_LAST = 8'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, WR_ISS, RD_ISS} state_t;

  state_t     state, state_nx;
  logic       last_rd;
  logic [7:0] timer;
  logic       wr_elig, rd_elig;
  logic       grant_wr, grant_rd;
  logic       wr_inc, rd_inc, tmo_hit;

  function automatic logic [CNT_WID-1:0] cnt_next(input logic [CNT_WID-1:0] cnt,
                                                   input logic inc, input logic dec);
    if (inc && !dec) return cnt + ONE;
    if (dec && !inc && cnt != '0) return cnt - ONE;
    return cnt;
  endfunction

  // Eligibility uses the registered counts, so a same-cycle done frees no credit yet
  always_comb begin
    state_nx = state;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    wr_inc   = 1'b0;
    rd_inc   = 1'b0;
    tmo_hit  = 1'b0;
    wr_elig  = wr_req && (wr_outst < MAX_C);
    rd_elig  = rd_req && (rd_outst < MAX_C);
    case (state)
      IDLE: begin
        if (wr_elig && (!rd_elig || last_rd)) begin
          state_nx = WR_ISS;
          grant_wr = 1'b1;
        end else if (rd_elig) begin
          state_nx = RD_ISS;
          grant_rd = 1'b1;
        end
      end
      WR_ISS: begin
        if (aw_hs) begin
          wr_inc   = 1'b1;
          state_nx = IDLE;
        end else if (timer == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
      end
      RD_ISS: begin
        if (ar_hs) begin
          rd_inc   = 1'b1;
          state_nx = IDLE;
        end else if (timer == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Timer reads 0 in the first ISS cycle; timeout fires after TMO_CYC ISS cycles
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      timer     <= '0;
      last_rd   <= 1'b1;
      wr_trn_en <= 1'b0;
      rd_trn_en <= 1'b0;
      tmo_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      timer     <= (state == IDLE || state_nx == IDLE) ? 8'd0 : timer + 8'd1;
      wr_trn_en <= grant_wr;
      rd_trn_en <= grant_rd;
      tmo_err   <= tmo_hit;
      busy      <= (state != IDLE) || (wr_outst != '0) || (rd_outst != '0);
      if (grant_wr) last_rd <= 1'b0;
      else if (grant_rd) last_rd <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_outst  <= '0;
      rd_outst  <= '0;
      unexp_err <= 1'b0;
    end else begin
      wr_outst <= cnt_next(wr_outst, wr_inc, wr_done);
      rd_outst <= cnt_next(rd_outst, rd_inc, rd_done);
      if ((wr_done && wr_outst == '0) || (rd_done && rd_outst == '0)) unexp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_txn_scheduler.sv
// Directed bench for axi4_txn_scheduler with MAX_OUTST=4 and TMO_CYC=8.
module tb_axi4_txn_scheduler;

  localparam int CW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic          aw_hs = 1'b0, ar_hs = 1'b0;
  logic          wr_done = 1'b0, rd_done = 1'b0;
  logic          wr_trn_en, rd_trn_en, busy, tmo_err, unexp_err;
  logic [CW-1:0] wr_outst, rd_outst;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi4_txn_scheduler #(.MAX_OUTST(4), .CNT_WID(CW), .TMO_CYC(8)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .aw_hs     (aw_hs),
    .ar_hs     (ar_hs),
    .wr_done   (wr_done),
    .rd_done   (rd_done),
    .wr_trn_en (wr_trn_en),
    .rd_trn_en (rd_trn_en),
    .wr_outst  (wr_outst),
    .rd_outst  (rd_outst),
    .busy      (busy),
    .tmo_err   (tmo_err),
    .unexp_err (unexp_err)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_trn_en"}, {31'd0, wr_trn_en}, 32'd0);
    chk({tag, "_rd_trn_en"}, {31'd0, rd_trn_en}, 32'd0);
    chk({tag, "_wr_outst"},  {28'd0, wr_outst},  32'd0);
    chk({tag, "_rd_outst"},  {28'd0, rd_outst},  32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_tmo_err"},   {31'd0, tmo_err},   32'd0);
    chk({tag, "_unexp_err"}, {31'd0, unexp_err}, 32'd0);
  endtask

  initial begin
    step(2);
    chk_all_zero("reset");
    ARESETn = 1'b1;
    step(1);

    // single write, handshake two cycles after the grant
    wr_req = 1'b1;
    step(1);
    chk("w1_grant", {31'd0, wr_trn_en}, 32'd1);
    chk("w1_no_rd", {31'd0, rd_trn_en}, 32'd0);
    wr_req = 1'b0;
    step(1);
    chk("w1_pulse_once", {31'd0, wr_trn_en}, 32'd0);
    step(1);
    aw_hs = 1'b1;
    step(1);
    aw_hs = 1'b0;
    chk("w1_outst", {28'd0, wr_outst}, 32'd1);
    step(1);
    chk("w1_no_regrant", {31'd0, wr_trn_en}, 32'd0);
    chk("w1_busy", {31'd0, busy}, 32'd1);
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    chk("w1_retired", {28'd0, wr_outst}, 32'd0);
    step(2);
    chk("w1_idle_busy", {31'd0, busy}, 32'd0);
    chk("w1_unexp", {31'd0, unexp_err}, 32'd0);

    // tie arbitration from reset: W,R,W,R
    ARESETn = 1'b0;
    step(1);
    ARESETn = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1; aw_hs = 1'b1; ar_hs = 1'b1;
    step(1);
    chk("tie1_w", {31'd0, wr_trn_en}, 32'd1);
    chk("tie1_r", {31'd0, rd_trn_en}, 32'd0);
    step(1);
    chk("tie1_cnt", {28'd0, wr_outst}, 32'd1);
    step(1);
    chk("tie2_r", {31'd0, rd_trn_en}, 32'd1);
    chk("tie2_w", {31'd0, wr_trn_en}, 32'd0);
    step(1);
    chk("tie2_cnt", {28'd0, rd_outst}, 32'd1);
    step(1);
    chk("tie3_w", {31'd0, wr_trn_en}, 32'd1);
    step(2);
    chk("tie4_r", {31'd0, rd_trn_en}, 32'd1);
    step(1);
    chk("tie_wr_outst", {28'd0, wr_outst}, 32'd2);
    chk("tie_rd_outst", {28'd0, rd_outst}, 32'd2);
    wr_req = 1'b0; rd_req = 1'b0;
    step(1);
    chk("tie_stop_w", {31'd0, wr_trn_en}, 32'd0);
    chk("tie_stop_r", {31'd0, rd_trn_en}, 32'd0);

    // credit limit: writes to 4, then blocked; reads still served
    wr_req = 1'b1;
    step(1);
    chk("cr_w3_grant", {31'd0, wr_trn_en}, 32'd1);
    step(1);
    chk("cr_w3_cnt", {28'd0, wr_outst}, 32'd3);
    step(1);
    chk("cr_w4_grant", {31'd0, wr_trn_en}, 32'd1);
    step(1);
    chk("cr_w4_cnt", {28'd0, wr_outst}, 32'd4);
    step(1);
    chk("cr_block_a", {31'd0, wr_trn_en}, 32'd0);
    step(2);
    chk("cr_block_b", {31'd0, wr_trn_en}, 32'd0);
    chk("cr_hold_cnt", {28'd0, wr_outst}, 32'd4);
    rd_req = 1'b1;
    step(1);
    chk("cr_rd_served", {31'd0, rd_trn_en}, 32'd1);
    rd_req = 1'b0;
    step(1);
    chk("cr_rd_cnt", {28'd0, rd_outst}, 32'd3);
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    chk("cr_done_cnt", {28'd0, wr_outst}, 32'd3);
    chk("cr_done_same_cycle", {31'd0, wr_trn_en}, 32'd0);
    step(1);
    chk("cr_w5_grant", {31'd0, wr_trn_en}, 32'd1);
    wr_req = 1'b0;
    step(1);
    chk("cr_w5_cnt", {28'd0, wr_outst}, 32'd4);

    // simultaneous handshake and done at count 2
    aw_hs = 1'b0; ar_hs = 1'b0;
    wr_done = 1'b1;
    step(1);
    chk("sim_drain3", {28'd0, wr_outst}, 32'd3);
    step(1);
    chk("sim_drain2", {28'd0, wr_outst}, 32'd2);
    wr_done = 1'b0;
    wr_req = 1'b1;
    step(1);
    chk("sim_grant", {31'd0, wr_trn_en}, 32'd1);
    wr_req = 1'b0; aw_hs = 1'b1; wr_done = 1'b1;
    step(1);
    aw_hs = 1'b0; wr_done = 1'b0;
    chk("sim_cnt_a", {28'd0, wr_outst}, 32'd2);
    step(1);
    chk("sim_cnt_b", {28'd0, wr_outst}, 32'd2);
    chk("sim_unexp", {31'd0, unexp_err}, 32'd0);

    // drain reads, then one stray rd_done
    rd_done = 1'b1;
    step(3);
    chk("ux_drained", {28'd0, rd_outst}, 32'd0);
    chk("ux_not_yet", {31'd0, unexp_err}, 32'd0);
    step(1);
    rd_done = 1'b0;
    chk("ux_no_underflow", {28'd0, rd_outst}, 32'd0);
    chk("ux_set", {31'd0, unexp_err}, 32'd1);
    step(2);
    chk("ux_sticky", {31'd0, unexp_err}, 32'd1);
    chk("ux_cnt_hold", {28'd0, rd_outst}, 32'd0);

    // timeout: no aw_hs for 8 ISS cycles, then re-grant
    wr_req = 1'b1;
    step(1);
    chk("tmo_grant", {31'd0, wr_trn_en}, 32'd1);
    step(7);
    chk("tmo_early", {31'd0, tmo_err}, 32'd0);
    chk("tmo_no_pulse", {31'd0, wr_trn_en}, 32'd0);
    step(1);
    chk("tmo_pulse", {31'd0, tmo_err}, 32'd1);
    chk("tmo_cnt", {28'd0, wr_outst}, 32'd2);
    step(1);
    chk("tmo_regrant", {31'd0, wr_trn_en}, 32'd1);
    chk("tmo_one_cycle", {31'd0, tmo_err}, 32'd0);
    wr_req = 1'b0; aw_hs = 1'b1;
    step(1);
    aw_hs = 1'b0;
    chk("tmo_after_cnt", {28'd0, wr_outst}, 32'd3);
    chk("tmo_busy", {31'd0, busy}, 32'd1);

    // async reset in the middle of WR_ISS
    wr_req = 1'b1;
    step(1);
    chk("ar_grant", {31'd0, wr_trn_en}, 32'd1);
    wr_req = 1'b0;
    ARESETn = 1'b0;
    #2;
    chk_all_zero("async_rst");
    step(2);
    ARESETn = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1; aw_hs = 1'b1; ar_hs = 1'b1;
    step(1);
    chk("ar_tie_w", {31'd0, wr_trn_en}, 32'd1);
    chk("ar_tie_r", {31'd0, rd_trn_en}, 32'd0);
    step(2);
    chk("ar_tie_next_r", {31'd0, rd_trn_en}, 32'd1);
    wr_req = 1'b0; rd_req = 1'b0; aw_hs = 1'b0; ar_hs = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
